alu_issue_unit: RTL and testbench

- Issue and writeback stage directly upstream of the alu. Holds an 8-entry register file and accepts 16-bit instructions over a valid/ready handshake.
- For each instruction it reads two source registers, drives in_a/in_b/opcode of the combinational alu, then writes the alu result and flags back.
- A host-side write port preloads registers, and a debug read port observes them.

---
 rtl/alu_issue_unit.sv | 151 +++++++++++++++
 tb/tb_alu_issue_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue and writeback stage sitting in front of a combinational alu.
// Holds an 8-entry register file. Takes one 16-bit instruction per 3 cycles over
// valid/ready. Reads two sources, drives the alu, then writes the result and flags back.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   instr_valid/instr_ready      instruction handshake
//   instr                        [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] unused
//   ext_we/ext_addr/ext_wdata    host register write port, honoured in every state
//   dbg_addr/dbg_data            combinational register-file read port
//   alu_a/alu_b/alu_op           registered operands and opcode to the alu
//   alu_out/alu_flags            alu result and {overflow, negative, zero}
//   result/flags_q               last written-back result and flags
//   done/illegal                 one-cycle pulses during writeback
module alu_issue_unit #(
  parameter int unsigned BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic          ext_we,
  input  logic [2:0]    ext_addr,
  input  logic [BW-1:0] ext_wdata,
  input  logic [2:0]    dbg_addr,
  output logic [BW-1:0] dbg_data,
  output logic [BW-1:0] alu_a,
  output logic [BW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [BW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  output logic [BW-1:0] result,
  output logic [2:0]    flags_q,
  output logic          done,
  output logic          illegal
);

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;
  localparam int unsigned OPW  = 4;
  localparam int unsigned FW   = 3;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state;
  logic [BW-1:0]   rf [NREG];
  logic [OPW-1:0]  op_q;
  logic [AW-1:0]   rd_q;
  logic [BW-1:0]   held_out;
  logic [FW-1:0]   held_flags;

  // Instruction field decode.
  logic [OPW-1:0]  instr_op;
  logic [AW-1:0]   instr_rd;
  logic [AW-1:0]   instr_ra;
  logic [AW-1:0]   instr_rb;
  logic            unused_instr_bits;

  assign instr_op          = instr[15:12];
  assign instr_rd          = instr[11:9];
  assign instr_ra          = instr[8:6];
  assign instr_rb          = instr[5:3];
  assign unused_instr_bits = ^instr[2:0];

  // A host write landing on the accept edge must be seen by EXEC, so forward it.
  logic [BW-1:0] src_a_c;
  logic [BW-1:0] src_b_c;

  assign src_a_c = (ext_we && (ext_addr == instr_ra)) ? ext_wdata : rf[instr_ra];
  assign src_b_c = (ext_we && (ext_addr == instr_rb)) ? ext_wdata : rf[instr_rb];

  logic accept_c;
  logic wb_we_c;

  assign accept_c = (state == IDLE) && instr_valid;
  // Opcodes with the top bit set are illegal and retire without a write.
  assign wb_we_c  = (state == WB) && !op_q[OPW-1];

  // Ready is a pure state decode, forced low while reset is held.
  assign instr_ready = (state == IDLE) && !rst;

  assign dbg_data = rf[dbg_addr];

  // Register file: writeback beats a colliding host write to the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ext_we && !(wb_we_c && (ext_addr == rd_q))) begin
        rf[ext_addr] <= ext_wdata;
      end
      if (wb_we_c) begin
        rf[rd_q] <= held_out;
      end
    end
  end

  // Issue/writeback sequencer with registered alu drive and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      held_out   <= '0;
      held_flags <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      result     <= '0;
      flags_q    <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_q   <= instr_op;
            rd_q   <= instr_rd;
            alu_a  <= src_a_c;
            alu_b  <= src_b_c;
            alu_op <= instr_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          held_out   <= alu_out;
          held_flags <= alu_flags;
          done       <= !op_q[OPW-1];
          illegal    <= op_q[OPW-1];
          state      <= WB;
        end
        WB: begin
          if (wb_we_c) begin
            result  <= held_out;
            flags_q <= held_flags;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural alu in the loop.
module tb_alu_issue_unit;

  localparam int unsigned BW = 16;

  logic          clk;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic          ext_we;
  logic [2:0]    ext_addr;
  logic [BW-1:0] ext_wdata;
  logic [2:0]    dbg_addr;
  logic [BW-1:0] dbg_data;
  logic [BW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic [BW-1:0] result;
  logic [2:0]    flags_q;
  logic          done;
  logic          illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_unit #(.BW(BW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .result(result), .flags_q(flags_q),
    .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 PASS A, 7 PASS B.
  logic ovf;
  always_comb begin
    ovf     = 1'b0;
    alu_out = '0;
    case (alu_op)
      4'd0: begin
        alu_out = alu_a + alu_b;
        ovf = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      4'd1: begin
        alu_out = alu_a - alu_b;
        ovf = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      4'd5: begin
        alu_out = alu_a + 16'd1;
        ovf = (alu_a == 16'h7FFF);
      end
      4'd6: alu_out = alu_a;
      4'd7: alu_out = alu_b;
      default: alu_out = '0;
    endcase
    alu_flags = {ovf, alu_out[15], (alu_out == 16'h0000)};
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [BW-1:0] d);
    ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    step();
    ext_we = 1'b0;
  endtask

  // Offers one instruction from IDLE; returns one cycle after the accept edge (EXEC).
  task automatic issue(input logic [15:0] i);
    instr_valid = 1'b1; instr = i;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic rd_rf(input logic [2:0] a, output logic [BW-1:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  logic [BW-1:0] v;
  int accepts;
  int dones;
  int first_acc;
  int gap;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; dbg_addr = '0;

    // Reset state.
    step();
    chk("rst_ready", 16'(instr_ready), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'h0000);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 16'(instr_ready), 16'd1);
    for (int i = 0; i < 8; i++) begin
      rd_rf(3'(i), v);
      chk("rf_zero", v, 16'h0000);
    end

    // ADD r3 <= r1 + r2.
    ext_write(3'd1, 16'h0002);
    ext_write(3'd2, 16'h0002);
    issue(16'h0650);
    chk("add_op", 16'(alu_op), 16'h0000);
    chk("add_a", alu_a, 16'h0002);
    chk("add_b", alu_b, 16'h0002);
    chk("exec_ready", 16'(instr_ready), 16'd0);
    chk("exec_done", 16'(done), 16'd0);
    step();
    chk("add_done", 16'(done), 16'd1);
    chk("add_illegal", 16'(illegal), 16'd0);
    step();
    rd_rf(3'd3, v);
    chk("add_rf3", v, 16'h0004);
    chk("add_result", result, 16'h0004);
    chk("add_flags", 16'(flags_q), 16'h0000);
    chk("add_done_low", 16'(done), 16'd0);

    // SUB with signed overflow, then a zero result.
    ext_write(3'd1, 16'h7FFF);
    ext_write(3'd2, 16'hFFFF);
    issue(16'h1850);
    step(); step();
    rd_rf(3'd4, v);
    chk("subov_rf4", v, 16'h8000);
    chk("subov_flags", 16'(flags_q), 16'h0006);
    ext_write(3'd1, 16'h000F);
    ext_write(3'd2, 16'h000F);
    issue(16'h1850);
    step(); step();
    chk("subz_result", result, 16'h0000);
    chk("subz_flags", 16'(flags_q), 16'h0001);

    // Backpressure: INC r5 held valid for 6 cycles.
    ext_write(3'd5, 16'hFFFF);
    dbg_addr = 3'd5;
    accepts = 0; dones = 0; first_acc = -1; gap = 0;
    instr_valid = 1'b1; instr = 16'h5B68;
    for (int i = 0; i < 6; i++) begin
      if (instr_ready) begin
        accepts++;
        if (first_acc < 0) first_acc = i;
        else gap = i - first_acc;
      end
      if (done) dones++;
      if (i == 3) chk("bp_r5_mid", dbg_data, 16'h0000);
      step();
    end
    instr_valid = 1'b0;
    chk("bp_accepts", 16'(accepts), 16'd2);
    chk("bp_gap", 16'(gap), 16'd3);
    chk("bp_dones", 16'(dones), 16'd2);
    rd_rf(3'd5, v);
    chk("bp_r5_end", v, 16'h0001);

    // Illegal opcode 1111 targeting r6.
    ext_write(3'd6, 16'h1234);
    issue(16'hFC50);
    step();
    chk("ill_pulse", 16'(illegal), 16'd1);
    chk("ill_done", 16'(done), 16'd0);
    step();
    rd_rf(3'd6, v);
    chk("ill_rf6", v, 16'h1234);
    chk("ill_result", result, 16'h0001);
    chk("ill_flags", 16'(flags_q), 16'h0000);
    chk("ill_pulse_low", 16'(illegal), 16'd0);

    // AND r7 with a colliding host write during WB.
    ext_write(3'd1, 16'h0FF0);
    ext_write(3'd2, 16'h00FF);
    issue(16'h2E50);
    step();
    ext_we = 1'b1; ext_addr = 3'd7; ext_wdata = 16'hBEEF;
    step();
    ext_we = 1'b0;
    rd_rf(3'd7, v);
    chk("coll_rf7", v, 16'h00F0);
    chk("coll_result", result, 16'h00F0);

    // Reset during EXEC of ADD r3.
    issue(16'h0650);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 16'(instr_ready), 16'd0);
    chk("mid_rst_result", result, 16'h0000);
    chk("mid_rst_alu_a", alu_a, 16'h0000);
    step();
    chk("mid_rst_done", 16'(done), 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 16'(instr_ready), 16'd1);
    rd_rf(3'd3, v);
    chk("post_rst_rf3", v, 16'h0000);
    step();
    chk("post_rst_done", 16'(done), 16'd0);
    step();
    chk("post_rst_done2", 16'(done), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
